// File: rtl/clock_divider_ctrl_pkg.sv
// Shared definitions for the SPI clock-divider controller.
//   state_t        : controller sequencing states
//   FACTOR_W       : default width of the divide-factor exponent
//   settle_timer_w : width needed to count SETTLE_PERIODS * 2**factor cycles
//                    for the largest factor a FACTOR_W-bit field can hold
package clock_divider_ctrl_pkg;

  localparam int FACTOR_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_RESET,
    S_SETTLE
  } state_t;

  // settle_periods * 2**max_exp is at most 2**(clog2(settle_periods) + max_exp),
  // so one extra bit beyond that exponent always holds the full count.
  function automatic int settle_timer_w(input int factor_w, input int settle_periods);
    return ((1 << factor_w) - 1) + $clog2(settle_periods) + 1;
  endfunction

endpackage

// File: rtl/clock_divider_ctrl_timer.sv
// Loadable down-counter shared by the drain, reset-hold and settle intervals.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   load        : load load_value (takes priority over enable)
//   load_value  : value to load; the interval lasts load_value+1 enabled cycles
//   enable      : decrement while nonzero
//   terminal    : count has reached zero
module clock_divider_ctrl_timer #(
  parameter int             W           = 8,
  parameter logic [W-1:0]   RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic         terminal
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/clock_divider_controller.sv
// Sequences divide-factor changes for the SPI clock divider: accepts a new
// factor over valid/ready, waits for the SPI engine to go idle, holds the
// divider in reset while the factor changes, waits for the divided clock to
// settle and then reports lock.
// Optional build macro: DRAIN_TIMEOUT_EN -- bounds the wait for spi_busy to
// DRAIN_TIMEOUT cycles and raises the sticky drain_timeout flag when hit.
// Ports:
//   S_AXI_CLK             : clock (shared with the divider)
//   ctrl_reset            : asynchronous active-high reset
//   factor_req_valid/value/ready : factor request handshake
//   spi_busy              : SPI engine mid-transaction
//   divider_reset         : reset to the clock divider
//   clock_divider_factor  : factor driven to the divider
//   divider_locked        : divided clock usable
//   factor_applied        : one-cycle pulse when a request completes
//   factor_clamped        : coincident pulse when that request was clamped
//   drain_timeout         : sticky timeout status (0 without DRAIN_TIMEOUT_EN)
module clock_divider_controller #(
  parameter int FACTOR_W       = clock_divider_ctrl_pkg::FACTOR_W,
  parameter int DEFAULT_FACTOR = 4,
  parameter int MAX_FACTOR     = 31,
  parameter int RESET_CYCLES   = 2,
  parameter int SETTLE_PERIODS = 2,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input  logic                S_AXI_CLK,
  input  logic                ctrl_reset,
  input  logic                factor_req_valid,
  input  logic [FACTOR_W-1:0] factor_req_value,
  output logic                factor_req_ready,
  input  logic                spi_busy,
  output logic                divider_reset,
  output logic [FACTOR_W-1:0] clock_divider_factor,
  output logic                divider_locked,
  output logic                factor_applied,
  output logic                factor_clamped,
  output logic                drain_timeout
);

  import clock_divider_ctrl_pkg::*;

  localparam int SETTLE_W = settle_timer_w(FACTOR_W, SETTLE_PERIODS);
  localparam int DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam int RESET_W  = $clog2(RESET_CYCLES + 1);
  localparam int TIMER_W  = (SETTLE_W > DRAIN_W)
                          ? ((SETTLE_W > RESET_W) ? SETTLE_W : RESET_W)
                          : ((DRAIN_W  > RESET_W) ? DRAIN_W  : RESET_W);

  // The counter resets to the reset-hold load so the post-reset sequence
  // holds divider_reset for the same RESET_CYCLES as a requested change.
  localparam logic [TIMER_W-1:0] RESET_LOAD = TIMER_W'(RESET_CYCLES - 1);
`ifdef DRAIN_TIMEOUT_EN
  localparam logic [TIMER_W-1:0] DRAIN_LOAD = TIMER_W'(DRAIN_TIMEOUT - 1);
`endif

  state_t               state;
  state_t               next_state;
  logic                 timer_load;
  logic                 timer_enable;
  logic                 timer_terminal;
  logic [TIMER_W-1:0]   timer_load_value;
  logic [TIMER_W-1:0]   settle_load;
  logic                 req_clamped;
  logic [FACTOR_W-1:0]  req_eff;
  logic [FACTOR_W-1:0]  eff_r;
  logic                 clamp_r;
  logic                 pending;
  logic                 take_same;
  logic                 take_new;
  logic                 start_reset;
  logic                 finish;
`ifdef DRAIN_TIMEOUT_EN
  logic                 timeout_hit;
`endif

  assign req_clamped = (factor_req_value > FACTOR_W'(MAX_FACTOR));
  assign req_eff     = req_clamped ? FACTOR_W'(MAX_FACTOR) : factor_req_value;

  // Settle interval is SETTLE_PERIODS * 2**factor cycles; factor 0 gives
  // SETTLE_PERIODS naturally.
  assign settle_load = (TIMER_W'(SETTLE_PERIODS) << clock_divider_factor) - TIMER_W'(1);

  assign factor_req_ready = (state == S_IDLE);
  assign divider_locked   = (state == S_IDLE);
  assign divider_reset    = (state == S_RESET);

  clock_divider_ctrl_timer #(
    .W           (TIMER_W),
    .RESET_VALUE (RESET_LOAD)
  ) u_timer (
    .clk        (S_AXI_CLK),
    .rst        (ctrl_reset),
    .load       (timer_load),
    .load_value (timer_load_value),
    .enable     (timer_enable),
    .terminal   (timer_terminal)
  );

  always_ff @(posedge S_AXI_CLK or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state <= S_RESET;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state       = state;
    timer_load       = 1'b0;
    timer_load_value = RESET_LOAD;
    timer_enable     = 1'b0;
    take_same        = 1'b0;
    take_new         = 1'b0;
    start_reset      = 1'b0;
    finish           = 1'b0;
`ifdef DRAIN_TIMEOUT_EN
    timeout_hit      = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (factor_req_valid) begin
          if (req_eff == clock_divider_factor) begin
            take_same = 1'b1;
          end else begin
            take_new   = 1'b1;
            next_state = S_DRAIN;
`ifdef DRAIN_TIMEOUT_EN
            timer_load       = 1'b1;
            timer_load_value = DRAIN_LOAD;
`endif
          end
        end
      end
      S_DRAIN: begin
`ifdef DRAIN_TIMEOUT_EN
        timer_enable = 1'b1;
        timeout_hit  = spi_busy && timer_terminal;
        start_reset  = !spi_busy || timer_terminal;
`else
        start_reset  = !spi_busy;
`endif
        if (start_reset) begin
          next_state       = S_RESET;
          timer_load       = 1'b1;
          timer_load_value = RESET_LOAD;
        end
      end
      S_RESET: begin
        timer_enable = 1'b1;
        if (timer_terminal) begin
          next_state       = S_SETTLE;
          timer_load       = 1'b1;
          timer_load_value = settle_load;
        end
      end
      S_SETTLE: begin
        timer_enable = 1'b1;
        if (timer_terminal) begin
          next_state = S_IDLE;
          finish     = 1'b1;
        end
      end
      default: begin
        next_state = S_RESET;
      end
    endcase
  end

  // pending marks a sequence started by a request; the post-reset sequence
  // runs with it clear, which is what suppresses its factor_applied pulse.
  always_ff @(posedge S_AXI_CLK or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      clock_divider_factor <= FACTOR_W'(DEFAULT_FACTOR);
      pending              <= 1'b0;
      clamp_r              <= 1'b0;
      factor_applied       <= 1'b0;
      factor_clamped       <= 1'b0;
    end else begin
      factor_applied <= 1'b0;
      factor_clamped <= 1'b0;
      if (take_same) begin
        factor_applied <= 1'b1;
        factor_clamped <= req_clamped;
      end
      if (take_new) begin
        pending <= 1'b1;
        clamp_r <= req_clamped;
      end
      if (start_reset) begin
        clock_divider_factor <= eff_r;
      end
      if (finish) begin
        factor_applied <= pending;
        factor_clamped <= pending & clamp_r;
        pending        <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_CLK) begin
    if (take_new) begin
      eff_r <= req_eff;
    end
  end

`ifdef DRAIN_TIMEOUT_EN
  always_ff @(posedge S_AXI_CLK or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      drain_timeout <= 1'b0;
    end else if (timeout_hit) begin
      drain_timeout <= 1'b1;
    end
  end
`else
  assign drain_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_clock_divider_controller.sv
// Self-checking bench for clock_divider_controller (MAX_FACTOR overridden to 10).
module tb_clock_divider_controller;

  localparam int FW    = 5;
  localparam int DEF   = 4;
  localparam int MAXF  = 10;
  localparam int RC    = 2;
  localparam int SP    = 2;
  localparam int DT    = 4096;
  localparam int LIMIT = 20000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [FW-1:0] value = '0;
  logic          ready;
  logic          busy = 1'b0;
  logic          dreset;
  logic [FW-1:0] factor;
  logic          locked;
  logic          applied;
  logic          clamped;
  logic          dto;

  int total = 0;
  int bad   = 0;
  int model_factor = DEF;
  logic model_dto = 1'b0;

  always #5 clk = ~clk;

  clock_divider_controller #(
    .FACTOR_W       (FW),
    .DEFAULT_FACTOR (DEF),
    .MAX_FACTOR     (MAXF),
    .RESET_CYCLES   (RC),
    .SETTLE_PERIODS (SP),
    .DRAIN_TIMEOUT  (DT)
  ) dut (
    .S_AXI_CLK            (clk),
    .ctrl_reset           (rst),
    .factor_req_valid     (valid),
    .factor_req_value     (value),
    .factor_req_ready     (ready),
    .spi_busy             (busy),
    .divider_reset        (dreset),
    .clock_divider_factor (factor),
    .divider_locked       (locked),
    .factor_applied       (applied),
    .factor_clamped       (clamped),
    .drain_timeout        (dto)
  );

  // Reference rules
  function automatic int eff_of(input int v);
    return (v > MAXF) ? MAXF : v;
  endfunction

  function automatic int settle_len(input int f);
    return SP * (1 << f);
  endfunction

  // Measures a reset-hold + settle sequence starting at a sample point where
  // divider_reset is expected high; ends at the first locked sample.
  task automatic measure_seq(input logic [FW-1:0] exp_f, output int n_rst,
                             output int n_settle, output int early, output int fbad);
    n_rst = 0; n_settle = 0; early = 0; fbad = 0;
    while (dreset === 1'b1 && n_rst < LIMIT) begin
      n_rst++;
      if (factor !== exp_f || locked !== 1'b0 || ready !== 1'b0) fbad++;
      if (applied !== 1'b0) early++;
      @(negedge clk);
    end
    while (locked !== 1'b1 && n_settle < LIMIT) begin
      n_settle++;
      if (dreset !== 1'b0 || ready !== 1'b0 || factor !== exp_f) fbad++;
      if (applied !== 1'b0) early++;
      @(negedge clk);
    end
  endtask

  task automatic check_startup(input string tag);
    int nr, ns, early, fb;
    measure_seq(FW'(DEF), nr, ns, early, fb);
    total++;
    if (nr != RC) begin bad++; $display("FAIL %s_reset_len: got %0d want %0d", tag, nr, RC); end
    total++;
    if (ns != settle_len(DEF)) begin bad++; $display("FAIL %s_settle_len: got %0d want %0d", tag, ns, settle_len(DEF)); end
    total++;
    if (early != 0 || fb != 0) begin bad++; $display("FAIL %s_during_seq: got pulses=%0d bad=%0d want 0/0", tag, early, fb); end
    total++;
    if ({locked, ready, dreset, applied, clamped} !== 5'b11000 || factor !== FW'(DEF)) begin
      bad++;
      $display("FAIL %s_lock: got lk/rdy/rst/app/clp=%b%b%b%b%b f=%0d want 11000 f=%0d",
               tag, locked, ready, dreset, applied, clamped, factor, DEF);
    end
    @(negedge clk);
    total++;
    if (applied !== 1'b0) begin bad++; $display("FAIL %s_no_applied: got %b want 0", tag, applied); end
    model_factor = DEF;
  endtask

  task automatic do_request(input int v, input int busy_cycles, input string tag);
    int eff, nr, ns, early, fb, viol;
    logic clamp;
    eff   = eff_of(v);
    clamp = (v > MAXF);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL %s_ready: got %b want 1", tag, ready); end
    valid = 1'b1; value = FW'(v); busy = (busy_cycles > 0);
    @(negedge clk);
    valid = 1'b0; value = FW'($urandom);
    if (eff == model_factor) begin
      total++;
      if ({applied, clamped, locked, dreset} !== {1'b1, clamp, 1'b1, 1'b0} || factor !== FW'(eff)) begin
        bad++;
        $display("FAIL %s_same_pulse: got app/clp/lk/rst=%b%b%b%b f=%0d want 1%b10 f=%0d",
                 tag, applied, clamped, locked, dreset, factor, clamp, eff);
      end
      @(negedge clk);
      total++;
      if ({applied, clamped, locked} !== 3'b001) begin
        bad++; $display("FAIL %s_same_after: got app/clp/lk=%b%b%b want 001", tag, applied, clamped, locked);
      end
      busy = 1'b0;
    end else begin
      total++;
      if ({ready, locked, dreset} !== 3'b000 || factor !== FW'(model_factor)) begin
        bad++;
        $display("FAIL %s_drain: got rdy/lk/rst=%b%b%b f=%0d want 000 f=%0d",
                 tag, ready, locked, dreset, factor, model_factor);
      end
      viol = 0;
      for (int i = 0; i < busy_cycles; i++) begin
        if (dreset !== 1'b0 || locked !== 1'b0 || factor !== FW'(model_factor)) viol++;
        valid = 1'b1; value = FW'($urandom);
        @(negedge clk);
      end
      valid = 1'b0; busy = 1'b0;
      @(negedge clk);
      total++;
      if (dreset !== 1'b1 || factor !== FW'(eff) || viol != 0) begin
        bad++;
        $display("FAIL %s_start: got rst=%b f=%0d drain_viol=%0d want 1 f=%0d 0", tag, dreset, factor, viol, eff);
      end
      measure_seq(FW'(eff), nr, ns, early, fb);
      total++;
      if (nr != RC) begin bad++; $display("FAIL %s_reset_len: got %0d want %0d", tag, nr, RC); end
      total++;
      if (ns != settle_len(eff)) begin bad++; $display("FAIL %s_settle_len: got %0d want %0d", tag, ns, settle_len(eff)); end
      total++;
      if (early != 0 || fb != 0) begin bad++; $display("FAIL %s_during_seq: got pulses=%0d bad=%0d want 0/0", tag, early, fb); end
      total++;
      if ({applied, clamped, locked, ready, dto} !== {1'b1, clamp, 1'b1, 1'b1, model_dto} || factor !== FW'(eff)) begin
        bad++;
        $display("FAIL %s_lock: got app/clp/lk/rdy/dto=%b%b%b%b%b f=%0d want 1%b11%b f=%0d",
                 tag, applied, clamped, locked, ready, dto, factor, clamp, model_dto, eff);
      end
      @(negedge clk);
      total++;
      if ({applied, clamped} !== 2'b00) begin bad++; $display("FAIL %s_pulse_len: got app/clp=%b%b want 00", tag, applied, clamped); end
      model_factor = eff;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; busy = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({dreset, locked, ready, applied, clamped, dto} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_outputs: got rst/lk/rdy/app/clp/dto=%b%b%b%b%b%b want 100000",
               dreset, locked, ready, applied, clamped, dto);
    end
    total++;
    if (factor !== FW'(DEF)) begin bad++; $display("FAIL reset_factor: got %0d want %0d", factor, DEF); end
    rst = 1'b0;
    check_startup("startup");
  endtask

  task automatic test_same_factor;  do_request(DEF, 0, "same");    endtask
  task automatic test_change;       do_request(6, 0, "change6");   endtask
  task automatic test_busy_hold;    do_request(2, 50, "busy50");   endtask
  task automatic test_factor_zero;  do_request(0, 3, "zero");      endtask

  task automatic test_clamp;
    do_request(20, 0, "clamp20");
    do_request(31, 0, "clamp_same");
  endtask

  task automatic test_random;
    int v, b;
    for (int i = 0; i < 8; i++) begin
      v = ($urandom_range(0, 3) == 0) ? model_factor : int'($urandom_range(0, 15));
      b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      do_request(v, b, "rand");
    end
  endtask

`ifdef DRAIN_TIMEOUT_EN
  task automatic test_drain_timeout;
    int tgt, d, early, nr, ns, fb;
    tgt = (model_factor == 3) ? 5 : 3;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL dto_ready: got %b want 1", ready); end
    valid = 1'b1; value = FW'(tgt); busy = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    d = 0; early = 0;
    while (dreset !== 1'b1 && d < LIMIT) begin
      d++;
      if (dto !== 1'b0) early++;
      @(negedge clk);
    end
    total++;
    if (d != DT || early != 0) begin bad++; $display("FAIL dto_wait: got %0d early=%0d want %0d 0", d, early, DT); end
    total++;
    if (dto !== 1'b1 || factor !== FW'(tgt)) begin bad++; $display("FAIL dto_set: got dto=%b f=%0d want 1 f=%0d", dto, factor, tgt); end
    measure_seq(FW'(tgt), nr, ns, early, fb);
    total++;
    if (nr != RC || ns != settle_len(tgt)) begin
      bad++; $display("FAIL dto_seq: got rst=%0d settle=%0d want %0d %0d", nr, ns, RC, settle_len(tgt));
    end
    total++;
    if ({applied, locked, dto} !== 3'b111) begin bad++; $display("FAIL dto_lock: got app/lk/dto=%b%b%b want 111", applied, locked, dto); end
    busy = 1'b0;
    @(negedge clk);
    model_factor = tgt;
    model_dto = 1'b1;
  endtask
`endif

  task automatic test_mid_reset;
    int c, tgt;
    tgt = (model_factor == 7) ? 8 : 7;
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", ready); end
    valid = 1'b1; value = FW'(tgt);
    @(negedge clk);
    valid = 1'b0;
    c = 0; while (dreset !== 1'b1 && c < LIMIT) begin c++; @(negedge clk); end
    c = 0; while (dreset === 1'b1 && c < LIMIT) begin c++; @(negedge clk); end
    repeat (20) @(negedge clk);
    total++;
    if (locked !== 1'b0 || factor !== FW'(tgt)) begin
      bad++; $display("FAIL abort_in_settle: got lk=%b f=%0d want 0 f=%0d", locked, factor, tgt);
    end
    rst = 1'b1;
    #1;
    total++;
    if (factor !== FW'(DEF) || {locked, ready, dreset, applied, clamped, dto} !== 6'b001000) begin
      bad++;
      $display("FAIL abort_reset: got f=%0d lk/rdy/rst/app/clp/dto=%b%b%b%b%b%b want f=%0d 001000",
               factor, locked, ready, dreset, applied, clamped, dto, DEF);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_dto = 1'b0;
    check_startup("abort");
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_same_factor;
    test_change;
    test_busy_hold;
    test_clamp;
    test_factor_zero;
    test_random;
`ifdef DRAIN_TIMEOUT_EN
    test_drain_timeout;
`endif
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
